// File: rtl/shift_register_sequenced_if.sv
// Control/data bundle for shift_register_sequenced: master drives commands, slave is the register.
interface shift_register_sequenced_if #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned SHIFT_STEP  = 1,
  parameter int unsigned COUNT_WIDTH = 4
);
  logic                   sys_reset;
  logic                   load;
  logic [WORD_LENGTH-1:0] parallelInput;
  logic                   shift;
  logic                   start;
  logic [1:0]             mode;
  logic [COUNT_WIDTH-1:0] shiftCount;
  logic [SHIFT_STEP-1:0]  serialInput;
  logic [SHIFT_STEP-1:0]  serialOutput;
  logic [WORD_LENGTH-1:0] parallelOutput;
  logic                   busy;
  logic                   done;
  logic                   sticky;

  modport master (
    output sys_reset, load, parallelInput, shift, start, mode, shiftCount, serialInput,
    input  serialOutput, parallelOutput, busy, done, sticky
  );

  modport slave (
    input  sys_reset, load, parallelInput, shift, start, mode, shiftCount, serialInput,
    output serialOutput, parallelOutput, busy, done, sticky
  );
endinterface

// File: rtl/shift_register_sequenced.sv
// Multi-mode shift register with a built-in N-shift sequencer and done pulse.
// Optional sticky shifted-out OR register enabled by defining SHIFT_REG_STICKY_EN.
module shift_register_sequenced #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned SHIFT_STEP  = 1,
  parameter int unsigned COUNT_WIDTH = 4
) (
  input logic                        clk,
  input logic                        reset,
  shift_register_sequenced_if.slave  bus
);
  localparam int unsigned W = WORD_LENGTH;
  localparam int unsigned S = SHIFT_STEP;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                 state_q, state_d;
  logic [W-1:0]           reg_q, reg_d;
  logic [S-1:0]           sout_q, sout_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]             mode_q, mode_d;
  logic                   done_q, done_d;

  logic [1:0]             shift_mode;
  logic [W-1:0]           shifted_val;
  logic [S-1:0]           shifted_out;
  logic                   do_shift;

  // Sequenced shifts use the mode latched at start; manual shifts use the live mode.
  assign shift_mode = (state_q == StRun) ? mode_q : bus.mode;

  always_comb begin
    shifted_val = reg_q;
    shifted_out = reg_q[S-1:0];
    unique case (shift_mode)
      2'b00: shifted_val = {bus.serialInput, reg_q[W-1:S]};
      2'b01: begin
        shifted_val = {reg_q[W-1-S:0], bus.serialInput};
        shifted_out = reg_q[W-1:W-S];
      end
      2'b10: shifted_val = {{S{reg_q[W-1]}}, reg_q[W-1:S]};
      2'b11: shifted_val = {reg_q[S-1:0], reg_q[W-1:S]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    reg_d    = reg_q;
    sout_d   = sout_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    do_shift = 1'b0;
    if (bus.sys_reset) begin
      state_d = StIdle;
      reg_d   = '0;
      sout_d  = '0;
      cnt_d   = '0;
      mode_d  = '0;
    end else if (bus.load) begin
      // Also aborts a running sequence without a done pulse.
      reg_d   = bus.parallelInput;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (bus.shiftCount == '0) begin
              done_d = 1'b1;
            end else begin
              mode_d  = bus.mode;
              cnt_d   = bus.shiftCount;
              state_d = StRun;
            end
          end else if (bus.shift) begin
            do_shift = 1'b1;
          end
        end
        StRun: begin
          do_shift = 1'b1;
          cnt_d    = cnt_q - COUNT_WIDTH'(1);
          if (cnt_q == COUNT_WIDTH'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      endcase
    end
    if (do_shift) begin
      reg_d  = shifted_val;
      sout_d = shifted_out;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      reg_q   <= '0;
      sout_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      sout_q  <= sout_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

`ifdef SHIFT_REG_STICKY_EN
  logic sticky_q, sticky_d;
  logic sticky_clr;

  assign sticky_clr = bus.sys_reset | bus.load | ((state_q == StIdle) & bus.start);

  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) begin
      sticky_d = 1'b0;
    end else if (do_shift && (shift_mode != 2'b01)) begin
      sticky_d = sticky_q | (|shifted_out);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign bus.sticky = sticky_q;
`else
  assign bus.sticky = 1'b0;
`endif

  assign bus.parallelOutput = reg_q;
  assign bus.serialOutput   = sout_q;
  assign bus.busy           = (state_q == StRun);
  assign bus.done           = done_q;
endmodule

// File: tb/tb_shift_register_sequenced.sv
// Randomized scoreboard bench for shift_register_sequenced against an arithmetic reference model.
module tb_shift_register_sequenced;
  localparam int unsigned W  = 8;
  localparam int unsigned S  = 1;
  localparam int unsigned CW = 4;
`ifdef SHIFT_REG_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] r;
    logic [S-1:0] sout;
    logic         sticky;
    int           busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  logic [W-1:0] m_r;
  logic [S-1:0] m_sout;
  logic         m_sticky;

  shift_register_sequenced_if #(.WORD_LENGTH(W), .SHIFT_STEP(S), .COUNT_WIDTH(CW)) dut_if ();

  shift_register_sequenced #(.WORD_LENGTH(W), .SHIFT_STEP(S), .COUNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference shift computed with plain arithmetic on whole words.
  task automatic apply(input logic [1:0] md, input logic [S-1:0] sin);
    logic [W-1:0] sinw;
    logic [W-1:0] outw;
    sinw = W'(sin);
    case (md)
      2'b00: begin
        outw = m_r & W'((1 << S) - 1);
        m_r  = (m_r >> S) | (sinw << (W - S));
      end
      2'b01: begin
        outw = m_r >> (W - S);
        m_r  = (m_r << S) | sinw;
      end
      2'b10: begin
        outw = m_r & W'((1 << S) - 1);
        m_r  = $signed(m_r) >>> S;
      end
      default: begin
        outw = m_r & W'((1 << S) - 1);
        m_r  = (m_r >> S) | (m_r << (W - S));
      end
    endcase
    m_sout = outw[S-1:0];
    if (md != 2'b01) m_sticky = m_sticky | (outw != '0);
  endtask

  task automatic model_reset();
    m_r      = '0;
    m_sout   = '0;
    m_sticky = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    dut_if.load          = 1'b1;
    dut_if.parallelInput = v;
    dut_if.start         = 1'($urandom);
    dut_if.shift         = 1'($urandom);
    dut_if.shiftCount    = CW'($urandom);
    tick();
    dut_if.load  = 1'b0;
    dut_if.start = 1'b0;
    dut_if.shift = 1'b0;
    m_r      = v;
    m_sticky = 1'b0;
  endtask

  task automatic manual(input logic [1:0] md, input logic [S-1:0] sin);
    dut_if.shift       = 1'b1;
    dut_if.mode        = md;
    dut_if.serialInput = sin;
    tick();
    dut_if.shift = 1'b0;
    apply(md, sin);
    check("manual_r", 32'(dut_if.parallelOutput), 32'(m_r));
    check("manual_sout", 32'(dut_if.serialOutput), 32'(m_sout));
  endtask

  task automatic run_seq(input logic [1:0] md, input int n, input int fixed_sin);
    logic [S-1:0] sins[$];
    exp_t e;
    m_sticky = 1'b0;
    for (int i = 0; i < n; i++) begin
      sins.push_back(fixed_sin < 0 ? S'($urandom) : S'(fixed_sin));
      apply(md, sins[i]);
    end
    e.r = m_r;
    e.sout = m_sout;
    e.sticky = m_sticky & STICKY_ON;
    e.busy = n;
    exp_q.push_back(e);
    dut_if.start      = 1'b1;
    dut_if.mode       = md;
    dut_if.shiftCount = CW'(n);
    dut_if.shift      = 1'($urandom);
    tick();
    for (int i = 0; i < n; i++) begin
      // Junk on mode/start/shift must be ignored while running.
      dut_if.mode        = 2'($urandom);
      dut_if.start       = 1'($urandom);
      dut_if.shift       = 1'($urandom);
      dut_if.shiftCount  = CW'($urandom);
      dut_if.serialInput = sins[i];
      tick();
    end
    dut_if.start = 1'b0;
    dut_if.shift = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_r"}, 32'(dut_if.parallelOutput), 32'h0);
    check({tag, "_sout"}, 32'(dut_if.serialOutput), 32'h0);
    check({tag, "_busy"}, 32'(dut_if.busy), 32'h0);
    check({tag, "_done"}, 32'(dut_if.done), 32'h0);
    check({tag, "_sticky"}, 32'(dut_if.sticky), 32'h0);
  endtask

  // Monitor: counts busy cycles and scores every done pulse against the queue.
  initial begin
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (dut_if.busy === 1'b1) begin
        busy_cnt++;
      end else begin
        if (dut_if.done === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 expected no done");
          end else begin
            e = exp_q.pop_front();
            check("seq_r", 32'(dut_if.parallelOutput), 32'(e.r));
            check("seq_sout", 32'(dut_if.serialOutput), 32'(e.sout));
            check("seq_sticky", 32'(dut_if.sticky), 32'(e.sticky));
            check("seq_busy_cycles", 32'(busy_cnt), 32'(e.busy));
          end
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    reset                = 1'b0;
    dut_if.sys_reset     = 1'b0;
    dut_if.load          = 1'b0;
    dut_if.parallelInput = '0;
    dut_if.shift         = 1'b0;
    dut_if.start         = 1'b0;
    dut_if.mode          = '0;
    dut_if.shiftCount    = '0;
    dut_if.serialInput   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    tick();

    do_load(8'h96);
    run_seq(2'b10, 3, -1);
    check("asr_r", 32'(dut_if.parallelOutput), 32'hF2);
    check("asr_sout", 32'(dut_if.serialOutput), 32'h1);
    check("asr_sticky", 32'(dut_if.sticky), 32'(STICKY_ON));

    do_load(8'h81);
    run_seq(2'b11, 1, -1);
    check("ror1_r", 32'(dut_if.parallelOutput), 32'hC0);
    run_seq(2'b11, 8, -1);
    check("ror8_r", 32'(dut_if.parallelOutput), 32'hC0);

    do_load(8'h0F);
    run_seq(2'b01, 4, 0);
    check("lsl_r", 32'(dut_if.parallelOutput), 32'hF0);
    check("lsl_sout", 32'(dut_if.serialOutput), 32'h0);

    do_load(8'h00);
    manual(2'b00, 1'b1);
    manual(2'b00, 1'b1);
    check("manual2_r", 32'(dut_if.parallelOutput), 32'hC0);
    run_seq(2'b10, 0, -1);
    check("cnt0_r", 32'(dut_if.parallelOutput), 32'hC0);

    // Load in the second run cycle aborts without done.
    do_load(8'h3C);
    dut_if.start = 1'b1; dut_if.mode = 2'b00; dut_if.shiftCount = CW'(5);
    tick();
    dut_if.start = 1'b0;
    dut_if.serialInput = S'($urandom);
    apply(2'b00, dut_if.serialInput);
    tick();
    dut_if.load = 1'b1; dut_if.parallelInput = 8'h55;
    tick();
    dut_if.load = 1'b0;
    m_r = 8'h55; m_sticky = 1'b0;
    check("abort_r", 32'(dut_if.parallelOutput), 32'h55);
    check("abort_busy", 32'(dut_if.busy), 32'h0);
    check("abort_sout", 32'(dut_if.serialOutput), 32'(m_sout));
    repeat (3) tick();

    // Synchronous clear mid-sequence.
    do_load(8'hA5);
    dut_if.start = 1'b1; dut_if.mode = 2'b11; dut_if.shiftCount = CW'(6);
    tick();
    dut_if.start = 1'b0;
    tick();
    dut_if.sys_reset = 1'b1;
    tick();
    dut_if.sys_reset = 1'b0;
    model_reset();
    check_zero("sys_reset");
    repeat (3) tick();

    // Asynchronous reset between edges mid-sequence.
    do_load(8'hE7);
    dut_if.start = 1'b1; dut_if.mode = 2'b10; dut_if.shiftCount = CW'(7);
    tick();
    dut_if.start = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (3) tick();

    repeat (40) begin
      case ($urandom_range(0, 3))
        0: do_load(W'($urandom));
        1: manual(2'($urandom), S'($urandom));
        default: run_seq(2'($urandom), int'($urandom_range(0, 15)), -1);
      endcase
    end

    repeat (4) tick();
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/shift_register_sequenced.md
Name: shift_register_sequenced

Overview:
- Parametrised successor to the team's single-bit right shift register.
- Adds configurable shift step, four shift modes (logical right/left, arithmetic right, rotate right) and a built-in shift sequencer: start with a count, run N shifts autonomously, pulse done.
- Serves the multiplier/divider/square-root datapaths as operand and remainder register, replacing external shift counters.

Parameters:
- WORD_LENGTH, 8: register width in bits (>=2).
- SHIFT_STEP, 1: bits moved per shift (1 <= SHIFT_STEP <= WORD_LENGTH-1).
- COUNT_WIDTH, 4: width of shiftCount; max sequence length 2^COUNT_WIDTH-1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous active-low reset; clears all state.
- sys_reset  in  1  synchronous clear, active-high.
- load  in  1  parallel load strobe.
- parallelInput  in  WORD_LENGTH  load data.
- shift  in  1  manual single shift, honoured only when idle.
- start  in  1  begin sequenced shift, honoured only when idle.
- mode  in  2  00 logical right, 01 logical left, 10 arithmetic right, 11 rotate right.
- shiftCount  in  COUNT_WIDTH  number of shifts for a sequence.
- serialInput  in  SHIFT_STEP  fill bits for logical modes.
- serialOutput  out  SHIFT_STEP  bits shifted out by the most recent shift.
- parallelOutput  out  WORD_LENGTH  register contents.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence completion.
- sticky  out  1  OR of bits shifted out (see Optional Feature).

Behaviour:
- Reset (reset=0, async): register, serialOutput, remaining count, latched mode, busy, done and sticky all 0. State machine goes to IDLE.
- Priority per edge: sys_reset > load > start > shift.
- sys_reset=1: same clear as async reset, synchronous.
- Shift operation, S=SHIFT_STEP, r=register:
  - 00 logical right: r <= {serialInput, r[W-1:S]}; serialOutput <= r[S-1:0].
  - 01 logical left: r <= {r[W-1-S:0], serialInput}; serialOutput <= r[W-1:W-S].
  - 10 arithmetic right: fill with S copies of r[W-1]; serialOutput <= r[S-1:0].
  - 11 rotate right: r <= {r[S-1:0], r[W-1:S]}; serialOutput <= r[S-1:0].
- serialOutput changes only on a shift; load does not alter it.
- States:
  - IDLE: busy=0.
    - load -> r <= parallelInput, stay IDLE.
    - start with shiftCount=0 -> done=1 next cycle, r unchanged, stay IDLE.
    - start with shiftCount=N>0 -> latch mode and N, go RUN.
    - shift -> one shift using live mode, stay IDLE.
  - RUN: busy=1.
    - One shift per edge using the latched mode; serialInput is sampled live each edge.
    - Decrement remaining count each shift; after the Nth shift go IDLE with done=1 for one cycle.
    - A sequence started at edge E0 shifts at edges E1..EN. busy is high between E0 and EN; done is high for the cycle after EN.
    - start and shift are ignored while in RUN.
    - load during RUN aborts: r <= parallelInput, go IDLE, no done pulse.
- done is a registered single-cycle pulse. A new start is accepted in the same cycle done is high.
- Async reset mid-sequence: immediate return to IDLE, no done.

Optional Feature:
- Macro: SHIFT_REG_STICKY_EN.
- Defined: sticky is a register.
  - Cleared on load, on start, and on any reset.
  - On each right-mode shift (00/10/11), sticky <= sticky | (|shifted-out bits).
  - Left shifts leave it unchanged.
  - Intended for divider/sqrt rounding.
- Undefined: sticky tied to 0; no extra flops.

Test Plan (WORD_LENGTH=8, SHIFT_STEP=1, COUNT_WIDTH=4):
- Load 0x96, start mode=10 count=3 -> busy high 3 cycles; r=0xF2; serialOutput=1; done pulse once; sticky=1 with macro, 0 without.
- Load 0x81, start mode=11 count=1 -> r=0xC0. Then start count=8 -> r returns to 0xC0 after 8 shifts; done once.
- Load 0x0F, start mode=01 count=4 with serialInput=0 -> r=0xF0, serialOutput=0.
- Idle manual shift: r=0x00, mode=00, serialInput=1, pulse shift twice -> r=0xC0. Then start count=0 -> done next cycle, r=0xC0.
- Load 0x55 in RUN cycle 2 of a count=5 sequence -> r=0x55, busy=0 next cycle, no done.
- sys_reset during RUN -> all outputs 0. Async reset asserted mid-cycle -> outputs 0 immediately without a clock edge.
